pio_in_irq: RTL and testbench
=============================

# pio_in_irq

Parametrised Avalon-MM input PIO slave for Platform Designer SoC systems (KEY, SW and similar board inputs). It extends the fixed 2-bit, data-only key port with configurable width, a metastability synchroniser, optional per-bit debounce, per-bit edge capture and a maskable level interrupt to the Nios II. It sits between board pins and the system interconnect.

## Interface
- WIDTH, 2: input bits, 1..32.
- SYNC_STAGES, 2: synchroniser flops per bit, ≥2.
- DEBOUNCE_CYCLES, 0: stable cycles required before the debounced value changes; 0 bypasses the debouncer.
- EDGE_TYPE, 1: 0 = rising, 1 = falling, 2 = any edge.
- RESET_VALUE, '0: WIDTH-bit reset value of the synchroniser, debounced and previous-value registers.
- clk  in  1  system clock.
- reset_n  in  1  asynchronous, active-low reset.
- address  in  2  word address.
- chipselect  in  1  slave select.
- write_n  in  1  active-low write strobe.
- writedata  in  32  write data.
- in_port  in  WIDTH  asynchronous pin inputs.
- readdata  out  32  registered read data; reset 0.
- irq  out  1  level interrupt; reset 0.

## Operation
- Register map:
  - 0: DATA (read-only, debounced value).
  - 2: IRQMASK (read/write, WIDTH bits).
  - 3: EDGECAP (read; write 1 to clear a bit).
  - 1: reads 0.
  - Writes to 0 and 1 are ignored.
- Upper readdata bits [31:WIDTH] are always 0.
- Write occurs when chipselect=1 and write_n=0; only writedata[WIDTH-1:0] is used.
- Synchroniser: SYNC_STAGES-flop chain per bit; its output is sync.
- Debounce (DEBOUNCE_CYCLES=D>0), per bit:
  - One counter per bit, sized $clog2(D+1).
  - The counter clears whenever sync == db.
  - Otherwise it increments; when it reaches D-1 while sync != db, db <= sync and the counter clears.
  - For D=0, db = sync.
- Edge detect: prev <= db every cycle; edge = db&~prev (rising), ~db&prev (falling), or db^prev (any).
- EDGECAP[i] <= 1 when edge[i]. A write-1 clear clears it; if set and clear coincide, set wins.
- irq = |(EDGECAP & IRQMASK), driven from registers with no extra flop.
- readdata is registered from the address mux every clock, independent of chipselect (read latency 1).
- Reset clears IRQMASK, EDGECAP and readdata. Sync, db and prev load RESET_VALUE, so no spurious edge occurs after reset when pins idle at RESET_VALUE. Debounce counters reset to 0.

## Timing
- Cycle reference: in_port changes before edge 0.
  - sync changes at edge SYNC_STAGES.
  - db changes at edge SYNC_STAGES+D (D=0: same as sync).
- DATA is visible in readdata one edge after db changes.
- EDGECAP bit and irq assert on that same edge.
- A glitch shorter than D cycles at sync never changes db.
- A clear write at edge n drops irq after edge n, unless another edge is captured on that same edge.
- Masking a pending bit drops irq the edge after the IRQMASK write. Unmasking a captured bit raises irq the edge after the write.
- Reset assertion mid-debounce or with pending captures clears everything immediately (asynchronous). Deassertion is synchronised externally by the system reset controller.

## Structure
- Package pio_in_pkg holds:
  - Register address constants ADDR_DATA=0, ADDR_IRQMASK=2, ADDR_EDGECAP=3.
  - EDGE_TYPE encodings EDGE_RISE, EDGE_FALL, EDGE_ANY.
- One sub-module, pio_debounce: synchroniser plus counter for a single bit, instantiated WIDTH times with a generate loop.
- The top level holds edge detect, registers, read mux and irq.

## Test plan
All scenarios use WIDTH=4, SYNC_STAGES=2, D=4, EDGE_TYPE=1 and RESET_VALUE=4'hF unless stated.
- Reset, pins idle at 4'hF: readdata=0 and irq=0 during reset. DATA reads 0x0000000F with no EDGECAP set.
- Drop in_port[1] for 3 cycles: DATA stays 0xF and EDGECAP stays 0. Hold it low ≥4 cycles: DATA=0xD at edge 7 and EDGECAP=0x2.
- IRQMASK=0x2, then press bit 1: irq rises with EDGECAP[1]. Write 0x2 to address 3: irq falls the next edge.
- EDGECAP clear on the same edge as a new falling edge on bit 1: bit stays 1 and irq stays high.
- IRQMASK=0 with EDGECAP=0x4: irq=0. Write IRQMASK=0x4: irq=1 the next edge. Address 1 reads 0. Writes to address 0 leave DATA unchanged.
- EDGE_TYPE=2, D=0: toggling bit 0 high then low sets EDGECAP[0] on each transition. Assert reset mid-press: all registers are cleared.

Source files
------------

// File: rtl/pio_in_irq_pkg.sv
// Shared constants for the input PIO: register word addresses and the
// encodings of the EDGE_TYPE parameter.
package pio_in_pkg;

    // Avalon word addresses of the slave registers
    localparam logic [1:0] ADDR_DATA    = 2'd0;
    localparam logic [1:0] ADDR_IRQMASK = 2'd2;
    localparam logic [1:0] ADDR_EDGECAP = 2'd3;

    // EDGE_TYPE encodings
    localparam int EDGE_RISE = 0;
    localparam int EDGE_FALL = 1;
    localparam int EDGE_ANY  = 2;

endpackage

// File: rtl/pio_in_irq_debounce.sv
// Single-bit input conditioner: a SYNC_STAGES-deep metastability chain
// followed by an optional stability counter. With DEBOUNCE_CYCLES=0 the
// synchroniser output is passed straight through.
module pio_debounce
    import pio_in_pkg::*;
#(
    parameter int   SYNC_STAGES     = 2,
    parameter int   DEBOUNCE_CYCLES = 0,
    parameter logic RESET_BIT       = 1'b0
) (
    input  logic clk,
    input  logic reset_n,
    input  logic pin,
    output logic db
);

    logic [SYNC_STAGES-1:0] sync_chain;
    logic                   sync;

    // Shift the raw pin through the synchroniser chain
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            sync_chain <= {SYNC_STAGES{RESET_BIT}};
        end else begin
            sync_chain <= {sync_chain[SYNC_STAGES-2:0], pin};
        end
    end

    assign sync = sync_chain[SYNC_STAGES-1];

    generate
        if (DEBOUNCE_CYCLES == 0) begin : g_bypass
            assign db = sync;
        end else begin : g_count
            localparam int CNT_W = $clog2(DEBOUNCE_CYCLES + 1);
            localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);

            logic [CNT_W-1:0] cnt;
            logic             db_q;

            // Count consecutive disagreeing cycles; adopt the new level once
            // the counter has seen it for DEBOUNCE_CYCLES samples
            always_ff @(posedge clk or negedge reset_n) begin
                if (!reset_n) begin
                    cnt  <= '0;
                    db_q <= RESET_BIT;
                end else if (sync == db_q) begin
                    cnt <= '0;
                end else if (cnt == CNT_LAST) begin
                    db_q <= sync;
                    cnt  <= '0;
                end else begin
                    cnt <= cnt + CNT_W'(1);
                end
            end

            assign db = db_q;
        end
    endgenerate

endmodule

// File: rtl/pio_in_irq.sv
// Avalon-MM input PIO with synchroniser, optional debounce, per-bit edge
// capture and a maskable level interrupt. Read latency is one clock.
module pio_in_irq
    import pio_in_pkg::*;
#(
    parameter int               WIDTH           = 2,
    parameter int               SYNC_STAGES     = 2,
    parameter int               DEBOUNCE_CYCLES = 0,
    parameter int               EDGE_TYPE       = 1,
    parameter logic [WIDTH-1:0] RESET_VALUE     = '0
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic [1:0]       address,
    input  logic             chipselect,
    input  logic             write_n,
    input  logic [31:0]      writedata,
    input  logic [WIDTH-1:0] in_port,
    output logic [31:0]      readdata,
    output logic             irq
);

    logic [WIDTH-1:0] db;
    logic [WIDTH-1:0] prev;
    logic [WIDTH-1:0] edge_hit;
    logic [WIDTH-1:0] irqmask;
    logic [WIDTH-1:0] edgecap;
    logic [WIDTH-1:0] clr_mask;
    logic [WIDTH-1:0] wr_data;
    logic             wr_en;
    logic [31:0]      rd_mux;

    // Per-bit synchroniser and debouncer
    for (genvar gi = 0; gi < WIDTH; gi++) begin : g_bit
        pio_debounce #(
            .SYNC_STAGES    (SYNC_STAGES),
            .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES),
            .RESET_BIT      (RESET_VALUE[gi])
        ) u_debounce (
            .clk    (clk),
            .reset_n(reset_n),
            .pin    (in_port[gi]),
            .db     (db[gi])
        );
    end

    // Bits above WIDTH on the write bus carry no register state
    if (WIDTH < 32) begin : g_wdata_hi
        logic unused_wdata_hi;
        assign unused_wdata_hi = ^writedata[31:WIDTH];
    end

    assign wr_en   = chipselect & ~write_n;
    assign wr_data = writedata[WIDTH-1:0];

    // Previous debounced value; reset to RESET_VALUE so idle pins give no edge
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            prev <= RESET_VALUE;
        end else begin
            prev <= db;
        end
    end

    // Select the edge polarity that gets captured
    always_comb begin
        edge_hit = db ^ prev;
        if (EDGE_TYPE == EDGE_RISE) begin
            edge_hit = db & ~prev;
        end else if (EDGE_TYPE == EDGE_FALL) begin
            edge_hit = ~db & prev;
        end else if (EDGE_TYPE == EDGE_ANY) begin
            edge_hit = db ^ prev;
        end
    end

    // Write-one-to-clear mask for EDGECAP
    always_comb begin
        clr_mask = '0;
        if (wr_en && (address == ADDR_EDGECAP)) begin
            clr_mask = wr_data;
        end
    end

    // Interrupt mask register
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            irqmask <= '0;
        end else if (wr_en && (address == ADDR_IRQMASK)) begin
            irqmask <= wr_data;
        end
    end

    // Edge capture: a new edge beats a simultaneous clear
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            edgecap <= '0;
        end else begin
            edgecap <= (edgecap & ~clr_mask) | edge_hit;
        end
    end

    // Read mux; unmapped addresses and bits above WIDTH read as zero
    always_comb begin
        rd_mux = '0;
        case (address)
            ADDR_DATA:    rd_mux[WIDTH-1:0] = db;
            ADDR_IRQMASK: rd_mux[WIDTH-1:0] = irqmask;
            ADDR_EDGECAP: rd_mux[WIDTH-1:0] = edgecap;
            default:      rd_mux = '0;
        endcase
    end

    // Registered read data, updated every clock regardless of chipselect
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            readdata <= '0;
        end else begin
            readdata <= rd_mux;
        end
    end

    assign irq = |(edgecap & irqmask);

endmodule

// File: tb/tb_pio_in_irq.sv
// Directed bench for pio_in_irq. Instance A: WIDTH=4, D=4, falling edges,
// reset value 4'hF. Instance B: WIDTH=4, D=0, any edge, reset value 4'hF.
// Both share the clock, reset and Avalon bus; each has its own pins.
module tb_pio_in_irq;

    logic        clk;
    logic        reset_n;
    logic [1:0]  address;
    logic        chipselect;
    logic        write_n;
    logic [31:0] writedata;
    logic [3:0]  a_in;
    logic [3:0]  b_in;
    logic [31:0] a_rd;
    logic [31:0] b_rd;
    logic        a_irq;
    logic        b_irq;

    int checks   = 0;
    int failures = 0;

    pio_in_irq #(
        .WIDTH(4), .SYNC_STAGES(2), .DEBOUNCE_CYCLES(4),
        .EDGE_TYPE(1), .RESET_VALUE(4'hF)
    ) u_dut_a (
        .clk(clk), .reset_n(reset_n), .address(address),
        .chipselect(chipselect), .write_n(write_n), .writedata(writedata),
        .in_port(a_in), .readdata(a_rd), .irq(a_irq)
    );

    pio_in_irq #(
        .WIDTH(4), .SYNC_STAGES(2), .DEBOUNCE_CYCLES(0),
        .EDGE_TYPE(2), .RESET_VALUE(4'hF)
    ) u_dut_b (
        .clk(clk), .reset_n(reset_n), .address(address),
        .chipselect(chipselect), .write_n(write_n), .writedata(writedata),
        .in_port(b_in), .readdata(b_rd), .irq(b_irq)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic check_eq(input string tag, input logic [31:0] got,
                            input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
        end
    endtask

    // Advance n rising edges, then settle 1 time unit past the last one
    task automatic tick(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    // Single-cycle Avalon write; address is left on the written register
    task automatic bus_write(input logic [1:0] a, input logic [31:0] d);
        address    = a;
        writedata  = d;
        chipselect = 1'b1;
        write_n    = 1'b0;
        tick(1);
        chipselect = 1'b0;
        write_n    = 1'b1;
        writedata  = '0;
    endtask

    initial begin
        reset_n    = 1'b0;
        address    = 2'd0;
        chipselect = 1'b0;
        write_n    = 1'b1;
        writedata  = '0;
        a_in       = 4'hF;
        b_in       = 4'hF;

        // Reset with pins idle at the reset value
        tick(2);
        check_eq("rst_rd", a_rd, 32'h0);
        check_eq("rst_irq", {31'b0, a_irq}, 32'h0);
        reset_n = 1'b1;
        tick(2);
        check_eq("idle_data", a_rd, 32'h0000_000F);
        check_eq("idle_irq", {31'b0, a_irq}, 32'h0);
        address = 2'd3;
        tick(1);
        check_eq("idle_edgecap", a_rd, 32'h0);

        // Three-cycle glitch on bit 1 is filtered
        address = 2'd0;
        a_in = 4'hD;
        tick(3);
        a_in = 4'hF;
        tick(10);
        check_eq("glitch_data", a_rd, 32'h0000_000F);
        address = 2'd3;
        tick(1);
        check_eq("glitch_edgecap", a_rd, 32'h0);

        // Mask bit 1, then press it: DATA and irq change at edge 7
        bus_write(2'd2, 32'h2);
        address = 2'd0;
        a_in = 4'hD;
        tick(6);
        check_eq("press_e6_data", a_rd, 32'h0000_000F);
        check_eq("press_e6_irq", {31'b0, a_irq}, 32'h0);
        tick(1);
        check_eq("press_e7_data", a_rd, 32'h0000_000D);
        check_eq("press_e7_irq", {31'b0, a_irq}, 32'h1);
        address = 2'd3;
        tick(1);
        check_eq("press_edgecap", a_rd, 32'h2);
        address = 2'd2;
        tick(1);
        check_eq("irqmask_rb", a_rd, 32'h2);

        // Write-one-to-clear drops irq on the next edge
        bus_write(2'd3, 32'h2);
        check_eq("clr_irq", {31'b0, a_irq}, 32'h0);
        tick(1);
        check_eq("clr_edgecap", a_rd, 32'h0);

        // Release bit 1: rising edge is not captured in falling mode
        a_in = 4'hF;
        tick(10);
        check_eq("rise_ignored", a_rd, 32'h0);
        check_eq("rise_irq", {31'b0, a_irq}, 32'h0);

        // Clear coinciding with a new falling edge: capture wins
        a_in = 4'hD;
        tick(6);
        bus_write(2'd3, 32'h2);
        check_eq("race_irq", {31'b0, a_irq}, 32'h1);
        tick(1);
        check_eq("race_edgecap", a_rd, 32'h2);
        bus_write(2'd3, 32'h2);
        check_eq("race_clr_irq", {31'b0, a_irq}, 32'h0);

        // Masked capture on bit 2, then unmask
        bus_write(2'd2, 32'h0);
        a_in = 4'h9;
        tick(8);
        check_eq("masked_irq", {31'b0, a_irq}, 32'h0);
        address = 2'd3;
        tick(1);
        check_eq("masked_edgecap", a_rd, 32'h4);
        bus_write(2'd2, 32'h4);
        check_eq("unmask_irq", {31'b0, a_irq}, 32'h1);
        address = 2'd1;
        tick(1);
        check_eq("addr1_zero", a_rd, 32'h0);
        bus_write(2'd0, 32'h0);
        address = 2'd0;
        tick(1);
        check_eq("data_wr_ignored", a_rd, 32'h0000_0009);

        // Instance B: any-edge capture without debounce
        b_in = 4'hE;
        tick(4);
        bus_write(2'd3, 32'h1);
        tick(1);
        check_eq("b_clr", b_rd, 32'h0);
        b_in = 4'hF;
        tick(3);
        check_eq("b_rise_e3", b_rd, 32'h0);
        tick(1);
        check_eq("b_rise_e4", b_rd, 32'h1);
        bus_write(2'd3, 32'h1);
        tick(1);
        check_eq("b_clr2", b_rd, 32'h0);
        b_in = 4'hE;
        tick(4);
        check_eq("b_fall", b_rd, 32'h1);
        check_eq("b_irq_masked", {31'b0, b_irq}, 32'h0);
        address = 2'd0;
        tick(1);
        check_eq("b_data", b_rd, 32'h0000_000E);

        // Asynchronous reset mid-debounce with a pending interrupt on A
        a_in = 4'h7;
        tick(3);
        #2;
        reset_n = 1'b0;
        #1;
        check_eq("arst_a_rd", a_rd, 32'h0);
        check_eq("arst_a_irq", {31'b0, a_irq}, 32'h0);
        check_eq("arst_b_rd", b_rd, 32'h0);
        a_in = 4'hF;
        b_in = 4'hF;
        tick(2);
        reset_n = 1'b1;
        tick(2);
        check_eq("post_a_data", a_rd, 32'h0000_000F);
        check_eq("post_b_data", b_rd, 32'h0000_000F);
        address = 2'd2;
        tick(1);
        check_eq("post_a_mask", a_rd, 32'h0);
        address = 2'd3;
        tick(1);
        check_eq("post_a_edgecap", a_rd, 32'h0);
        check_eq("post_b_edgecap", b_rd, 32'h0);
        check_eq("post_a_irq", {31'b0, a_irq}, 32'h0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
